// File: rtl/deal_sequencer.sv
// Baccarat deal sequencer: captures generator cards into six hand slots on step pulses and flags the winner.
// Optional third-card drawing rules are enabled by defining DEAL_SEQUENCER_THIRD_CARD_EN.
module deal_sequencer (
  input  logic       clock,
  input  logic       resetb,
  input  logic       step,
  input  logic [3:0] new_card,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic       player_win,
  output logic       dealer_win,
  output logic       done
);

  typedef enum logic [2:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_D3, S_DONE
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3;
  logic [3:0] r_dcard1, r_dcard2, r_dcard3;
  logic [4:0] w_psum, w_dsum;

  // Face cards, tens and anything outside 1-9 (including empty) count zero.
  function automatic logic [4:0] card_val(input logic [3:0] c);
    return (c >= 4'd1 && c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] t;
    if (s >= 5'd20)      t = s - 5'd20;
    else if (s >= 5'd10) t = s - 5'd10;
    else                 t = s;
    return t[3:0];
  endfunction

  function automatic logic dealer_draws(input logic [3:0] ds, input logic [4:0] v);
    case (ds)
      4'd0, 4'd1, 4'd2: return 1'b1;
      4'd3:             return v != 5'd8;
      4'd4:             return v >= 5'd2 && v <= 5'd7;
      4'd5:             return v >= 5'd4 && v <= 5'd7;
      4'd6:             return v == 5'd6 || v == 5'd7;
      default:          return 1'b0;
    endcase
  endfunction

  assign w_psum = card_val(r_pcard1) + card_val(r_pcard2) + card_val(r_pcard3);
  assign w_dsum = card_val(r_dcard1) + card_val(r_dcard2) + card_val(r_dcard3);
  assign pscore = mod10(w_psum);
  assign dscore = mod10(w_dsum);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_P1:   if (step) w_next = S_D1;
      S_D1:   if (step) w_next = S_P2;
      S_P2:   if (step) w_next = S_D2;
      S_D2:   if (step) w_next = S_EVAL;
      S_EVAL: begin
`ifdef DEAL_SEQUENCER_THIRD_CARD_EN
        if (pscore >= 4'd8 || dscore >= 4'd8) w_next = S_DONE;
        else if (pscore <= 4'd5)              w_next = S_P3;
        else if (dscore <= 4'd5)              w_next = S_D3;
        else                                  w_next = S_DONE;
`else
        w_next = S_DONE;
`endif
      end
      // Dealer decision uses the player's third card as it is captured.
      S_P3:   if (step) w_next = dealer_draws(dscore, card_val(new_card)) ? S_D3 : S_DONE;
      S_D3:   if (step) w_next = S_DONE;
      S_DONE: if (step) w_next = S_P1;
      default: w_next = S_P1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetb) begin
      r_state  <= S_P1;
      r_pcard1 <= 4'd0;
      r_pcard2 <= 4'd0;
      r_pcard3 <= 4'd0;
      r_dcard1 <= 4'd0;
      r_dcard2 <= 4'd0;
      r_dcard3 <= 4'd0;
    end else begin
      r_state <= w_next;
      if (step) begin
        case (r_state)
          S_P1: r_pcard1 <= new_card;
          S_D1: r_dcard1 <= new_card;
          S_P2: r_pcard2 <= new_card;
          S_D2: r_dcard2 <= new_card;
`ifdef DEAL_SEQUENCER_THIRD_CARD_EN
          S_P3: r_pcard3 <= new_card;
          S_D3: r_dcard3 <= new_card;
`endif
          S_DONE: begin
            r_pcard1 <= 4'd0;
            r_pcard2 <= 4'd0;
            r_pcard3 <= 4'd0;
            r_dcard1 <= 4'd0;
            r_dcard2 <= 4'd0;
            r_dcard3 <= 4'd0;
          end
          default: ;
        endcase
      end
    end
  end

  assign pcard1     = r_pcard1;
  assign pcard2     = r_pcard2;
  assign pcard3     = r_pcard3;
  assign dcard1     = r_dcard1;
  assign dcard2     = r_dcard2;
  assign dcard3     = r_dcard3;
  assign done       = (r_state == S_DONE);
  assign player_win = done && (pscore > dscore);
  assign dealer_win = done && (dscore > pscore);

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer; expectations follow DEAL_SEQUENCER_THIRD_CARD_EN when defined.
module tb_deal_sequencer;

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       step = 1'b0;
  logic [3:0] new_card = 4'd0;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic       player_win, dealer_win, done;

  int errors = 0;
  int checks = 0;

  deal_sequencer dut (
    .clock(clock), .resetb(resetb), .step(step), .new_card(new_card),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3(pcard3),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore),
    .player_win(player_win), .dealer_win(dealer_win), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the following rising edge samples them.
  task automatic do_step(input logic [3:0] card);
    @(negedge clock);
    step = 1'b1;
    new_card = card;
    @(negedge clock);
    step = 1'b0;
  endtask

  task automatic idle();
    @(negedge clock);
  endtask

  task automatic chk_result(input string tag, input int d, input int pw, input int dw);
    chk({tag, "_done"}, done, d);
    chk({tag, "_pwin"}, player_win, pw);
    chk({tag, "_dwin"}, dealer_win, dw);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_p1"}, pcard1, 0);
    chk({tag, "_p2"}, pcard2, 0);
    chk({tag, "_p3"}, pcard3, 0);
    chk({tag, "_d1"}, dcard1, 0);
    chk({tag, "_d2"}, dcard2, 0);
    chk({tag, "_d3"}, dcard3, 0);
  endtask

  initial begin
    // Reset
    resetb = 1'b0;
    idle(); idle();
    resetb = 1'b1;
    chk_empty("rst");
    chk("rst_pscore", pscore, 0);
    chk("rst_dscore", dscore, 0);
    chk_result("rst", 0, 0, 0);

    // Hand 1: 4,2,5,3 -> natural 9 vs 5
    do_step(4); do_step(2); do_step(5); do_step(3);
    chk("h1_pscore", pscore, 9);
    chk("h1_dscore", dscore, 5);
    chk("h1_done_eval", done, 0);
    idle();
    chk_result("h1", 1, 1, 0);

    // Step in S_DONE clears slots; the card on that edge is not captured
    do_step(7);
    chk_empty("clr");
    chk_result("clr", 0, 0, 0);
    do_step(2);
    chk("clr_next_p1", pcard1, 2);
    chk("clr_next_d1", dcard1, 0);

    // Reset mid-hand overrides a simultaneous step
    do_step(6);
    @(negedge clock);
    resetb = 1'b0; step = 1'b1; new_card = 4'd8;
    @(negedge clock);
    resetb = 1'b1; step = 1'b0;
    chk_empty("mrst");
    chk("mrst_done", done, 0);
    do_step(7);
    chk("mrst_p1", pcard1, 7);
    chk("mrst_d1", dcard1, 0);
    do_step(14);
    chk("oor_d1_stored", dcard1, 14);
    chk("oor_dscore", dscore, 0);
    chk("oor_pscore", pscore, 7);
    do_step(1); do_step(1);
    idle();
    // 8 vs 1 natural
    chk_result("oor", 1, 1, 0);
    do_step(0);

    // Hand 2: 9,1,9,1 with step held through D2 and S_EVAL edges
    do_step(9); do_step(1); do_step(9);
    @(negedge clock);
    step = 1'b1; new_card = 4'd1;
    @(negedge clock);
    new_card = 4'd5;
    @(negedge clock);
    step = 1'b0;
    chk("h2_pscore", pscore, 8);
    chk("h2_dscore", dscore, 2);
    chk("h2_p3", pcard3, 0);
    chk("h2_d3", dcard3, 0);
    chk("h2_d2_kept", dcard2, 1);
    chk_result("h2", 1, 1, 0);
    do_step(0);

    // Hand 3: 1,3,2,3 -> player 3 draws, dealer 6
    do_step(1); do_step(3); do_step(2); do_step(3);
    chk("h3_pscore", pscore, 3);
    chk("h3_dscore", dscore, 6);
    idle();
`ifdef DEAL_SEQUENCER_THIRD_CARD_EN
    chk("h3_done_p3", done, 0);
    do_step(6);
    chk("h3_p3", pcard3, 6);
    chk("h3_pscore3", pscore, 9);
    chk("h3_done_d3", done, 0);
    do_step(1);
    chk("h3_d3", dcard3, 1);
    chk("h3_dscore3", dscore, 7);
    chk_result("h3", 1, 1, 0);
`else
    chk_result("h3", 1, 0, 1);
    chk("h3_p3", pcard3, 0);
`endif
    do_step(0);

    // Hand 4: 13,3,7,4 -> 7 vs 7 tie
    do_step(13); do_step(3); do_step(7); do_step(4);
    chk("h4_pscore", pscore, 7);
    chk("h4_dscore", dscore, 7);
    idle();
    chk_result("h4", 1, 0, 0);
    do_step(0);

    // Hand 5: 10,2,6,3 -> player stands on 6, dealer 5
    do_step(10); do_step(2); do_step(6); do_step(3);
    chk("h5_pscore", pscore, 6);
    chk("h5_dscore", dscore, 5);
    idle();
`ifdef DEAL_SEQUENCER_THIRD_CARD_EN
    chk("h5_done_d3", done, 0);
    do_step(4);
    chk("h5_p3", pcard3, 0);
    chk("h5_d3", dcard3, 4);
    chk("h5_dscore3", dscore, 9);
    chk_result("h5", 1, 0, 1);
`else
    chk_result("h5", 1, 1, 0);
    do_step(4);
    chk_empty("h5_clr");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
